// File: rtl/if_id_queue.sv
// Decoupled IF/ID queue: DEPTH-entry FIFO of {pc, inst} pairs.
// Valid/ready on both sides, synchronous flush, zero bubble outputs.
module if_id_queue #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic                     out_have_inst,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("if_id_queue: DEPTH must be a power of two >= 2");
    end

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    ptr_t              rp;
    ptr_t              wp;
    cnt_t              cnt;
    logic              push;
    logic              pop;

    assign in_ready  = (cnt != CNT_FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Empty slots read as the all-zero bubble, whatever the array holds.
    assign out_pc        = out_valid ? mem_pc[rp] : '0;
    assign out_inst      = out_valid ? mem_inst[rp] : '0;
    assign out_have_inst = out_valid & (out_inst != '0);
    assign level         = cnt;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            mem_pc   <= '{default: '0};
            mem_inst <= '{default: '0};
            rp       <= '0;
            wp       <= '0;
            cnt      <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem_pc[wp]   <= in_pc;
                mem_inst[wp] <= in_inst;
                wp           <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed vector table plus reset and randomised scoreboard checks
// for if_id_queue (DEPTH=2 and a 64-bit pc / DEPTH=8 instance).
module tb_if_id_queue;

    logic        clk;
    logic        rst_n;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_have;
    logic [1:0]  level;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [63:0] b_in_pc;
    logic [31:0] b_in_inst;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [63:0] b_out_pc;
    logic [31:0] b_out_inst;
    logic        b_out_have;
    logic [3:0]  b_level;

    int errors = 0;
    int checks = 0;

    if_id_queue dut (
        .cpu_clk       (clk),
        .cpu_rst_n     (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_have_inst (out_have),
        .level         (level)
    );

    if_id_queue #(.PC_W(64), .INST_W(32), .DEPTH(8)) dut8 (
        .cpu_clk       (clk),
        .cpu_rst_n     (rst_n),
        .flush         (b_flush),
        .in_valid      (b_in_valid),
        .in_ready      (b_in_ready),
        .in_pc         (b_in_pc),
        .in_inst       (b_in_inst),
        .out_valid     (b_out_valid),
        .out_ready     (b_out_ready),
        .out_pc        (b_out_pc),
        .out_inst      (b_out_inst),
        .out_have_inst (b_out_have),
        .level         (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_hv;
        logic [1:0]  e_lv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic e_ir, input logic e_ov,
                       input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_hv, input logic [1:0] e_lv);
        vec_t v;
        v.name = nm; v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst;
        v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_hv = e_hv; v.e_lv = e_lv;
        vecs.push_back(v);
    endtask

    // Packed view: {in_ready, out_valid, have, level, pc, inst}
    function automatic logic [68:0] pack_small();
        return {in_ready, out_valid, out_have, level, out_pc, out_inst};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 0; in_valid = 0; in_pc = '0; in_inst = '0; out_ready = 0;
    endtask

    logic [31:0] ipc;
    logic [31:0] iinst;
    logic [31:0] ppc;
    logic [31:0] pinst;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } pair_t;

    pair_t sb[$];

    initial begin
        drive_idle();
        b_flush = 0; b_in_valid = 0; b_in_pc = '0;
        b_in_inst = '0; b_out_ready = 0;
        rst_n = 0;

        // Directed vector table (DEPTH=2 instance)
        for (int k = 0; k < 10; k++) begin
            ipc   = 32'(k * 4);
            iinst = 32'h0000_0013 | 32'(k << 7);
            add("stream", 0, 1, ipc, iinst, 1, 1, 1, ipc, iinst, 1, 2'd1);
        end
        add("stream_drain", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0);
        add("empty_ordy", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0);
        add("bp_push0", 0, 1, 32'h100, 32'h1, 0,
            1, 1, 32'h100, 32'h1, 1, 2'd1);
        add("bp_push1", 0, 1, 32'h104, 32'h2, 0,
            0, 1, 32'h100, 32'h1, 1, 2'd2);
        add("bp_hold", 0, 1, 32'h108, 32'h3, 0,
            0, 1, 32'h100, 32'h1, 1, 2'd2);
        add("bp_pop_full", 0, 1, 32'h108, 32'h3, 1,
            1, 1, 32'h104, 32'h2, 1, 2'd1);
        add("bp_pushpop", 0, 1, 32'h108, 32'h3, 1,
            1, 1, 32'h108, 32'h3, 1, 2'd1);
        add("bp_drain", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0);
        add("fl_fill0", 0, 1, 32'h180, 32'h11, 0,
            1, 1, 32'h180, 32'h11, 1, 2'd1);
        add("fl_fill1", 0, 1, 32'h184, 32'h12, 0,
            0, 1, 32'h180, 32'h11, 1, 2'd2);
        add("fl_flush", 1, 1, 32'h200, 32'h21, 1,
            1, 0, 0, 0, 0, 2'd0);
        add("fl_after", 0, 1, 32'h300, 32'h31, 0,
            1, 1, 32'h300, 32'h31, 1, 2'd1);
        add("fl_single", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0);
        add("zero_inst", 0, 1, 32'h40, 32'h0, 0,
            1, 1, 32'h40, 32'h0, 0, 2'd1);
        add("nz_inst", 0, 1, 32'h44, 32'h13, 1,
            1, 1, 32'h44, 32'h13, 1, 2'd1);
        add("zero_drain", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0);
        add("flush_one0", 0, 1, 32'h500, 32'h55, 0,
            1, 1, 32'h500, 32'h55, 1, 2'd1);
        add("flush_one1", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0);

        // Reset state
        #2;
        chk("reset_state", 128'(pack_small()),
            128'({1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0}));
        chk("reset_state8", 128'({b_in_ready, b_out_valid, b_level}),
            128'({1'b1, 1'b0, 4'd0}));
        @(posedge clk); #1;
        rst_n = 1;

        foreach (vecs[i]) begin
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_pc     = vecs[i].pc;
            in_inst   = vecs[i].inst;
            out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("%s[%0d]", vecs[i].name, i), 128'(pack_small()),
                128'({vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_hv,
                      vecs[i].e_lv, vecs[i].e_pc, vecs[i].e_inst}));
        end
        drive_idle();

        // Asynchronous reset mid-stream with two entries held
        in_valid = 1; in_pc = 32'h700; in_inst = 32'h77;
        @(posedge clk); #1;
        in_pc = 32'h704; in_inst = 32'h78;
        @(posedge clk); #1;
        chk("pre_reset_full", 128'({level, out_pc}),
            128'({2'd2, 32'h700}));
        #2;
        rst_n = 0;
        #1;
        chk("async_reset", 128'(pack_small()),
            128'({1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0}));
        @(posedge clk); #1;
        chk("reset_held", 128'(pack_small()),
            128'({1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0}));
        rst_n = 1;
        in_pc = 32'h1000; in_inst = 32'h0280_0413;
        @(posedge clk); #1;
        in_valid = 0;
        chk("post_reset_push", 128'(pack_small()),
            128'({1'b1, 1'b1, 1'b1, 2'd1, 32'h1000, 32'h0280_0413}));
        out_ready = 1;
        @(posedge clk); #1;
        drive_idle();
        chk("post_reset_drain", 128'({out_valid, level}),
            128'({1'b0, 2'd0}));

        // Random sweep on the DEPTH=8 instance against a scoreboard
        for (int c = 0; c < 600; c++) begin
            logic v;
            logic r;
            logic f;
            logic mpush;
            logic mpop;
            pair_t p;
            pair_t h;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 2);
            p.pc   = {$urandom, $urandom};
            p.inst = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
            b_flush = f; b_in_valid = v; b_out_ready = r;
            b_in_pc = p.pc; b_in_inst = p.inst;
            mpush = v & (sb.size() != 8) & ~f;
            mpop  = r & (sb.size() != 0) & ~f;
            @(posedge clk); #1;
            if (f) begin
                sb.delete();
            end else begin
                if (mpop) void'(sb.pop_front());
                if (mpush) sb.push_back(p);
            end
            if (sb.size() != 0) h = sb[0];
            else begin
                h.pc = '0; h.inst = '0;
            end
            chk($sformatf("sweep[%0d]", c),
                128'({b_in_ready, b_out_valid, b_out_have, b_level,
                      b_out_pc, b_out_inst}),
                128'({sb.size() != 8, sb.size() != 0,
                      (sb.size() != 0) && (h.inst != 0),
                      4'(sb.size()), h.pc, h.inst}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
